// File: rtl/rf_multiport.sv
// Multi-read-port register file with write forwarding and a
// sequential clear engine that walks every address once.
module rf_multiport #(
   parameter int WD       = 32,
   parameter int SEL      = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Reg_Write_i,
   input  logic [SEL-1:0]    Write_Register_i,
   input  logic [WD-1:0]     Write_Data_i,
   input  logic [NRD*SEL-1:0] Read_Register_i,
   output logic [NRD*WD-1:0] Read_Data_o,
   input  logic              Clear_i,
   output logic              Busy_o,
   output logic              Write_Drop_o
);

   localparam int DEPTH = 2**SEL;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [SEL-1:0] cnt;
   logic [WD-1:0]  regs [DEPTH];
   logic           wr_en;
   logic           wr_ok;

   assign wr_en = (state == IDLE) && Reg_Write_i;
   assign wr_ok = wr_en &&
                  !((ZERO_REG != 0) && (Write_Register_i == '0));

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (Clear_i) state_nxt = CLEAR;
         CLEAR:   if (&cnt) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         Write_Drop_o <= 1'b0;
      end else begin
         state        <= state_nxt;
         Write_Drop_o <= (state == CLEAR) && Reg_Write_i;
         if (state == IDLE) cnt <= '0;
         else               cnt <= cnt + 1'b1;
      end
   end

   // Clear walk owns the array while active; writes are locked out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (state == CLEAR) begin
         regs[cnt] <= '0;
      end else if (wr_ok) begin
         regs[Write_Register_i] <= Write_Data_i;
      end
   end

   assign Busy_o = (state == CLEAR);

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [SEL-1:0] ra;
      logic           zro;
      logic           hit;
      assign ra  = Read_Register_i[k*SEL +: SEL];
      assign zro = (ZERO_REG != 0) && (ra == '0);
      assign hit = (BYPASS != 0) && wr_en &&
                   (ra == Write_Register_i);
      assign Read_Data_o[k*WD +: WD] =
         zro ? '0 : (hit ? Write_Data_i : regs[ra]);
   end

endmodule

// File: tb/tb_rf_multiport.sv
// Randomized bench for rf_multiport against an array-based model,
// with a forwarding and a non-forwarding instance side by side.
module tb_rf_multiport;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  ra0;
   logic [4:0]  ra1;
   logic        clr;
   logic [63:0] rd_b;
   logic [63:0] rd_nb;
   logic        busy_b;
   logic        busy_nb;
   logic        drop_b;
   logic        drop_nb;

   int checks;
   int failures;

   logic [31:0] mdl [32];
   bit          m_busy;
   int          m_idx;
   bit          m_drop;

   rf_multiport u_dut (
      .clk              (clk),
      .reset            (reset),
      .Reg_Write_i      (we),
      .Write_Register_i (wa),
      .Write_Data_i     (wd),
      .Read_Register_i  ({ra1, ra0}),
      .Read_Data_o      (rd_b),
      .Clear_i          (clr),
      .Busy_o           (busy_b),
      .Write_Drop_o     (drop_b)
   );

   rf_multiport #(.BYPASS(0)) u_nb (
      .clk              (clk),
      .reset            (reset),
      .Reg_Write_i      (we),
      .Write_Register_i (wa),
      .Write_Data_i     (wd),
      .Read_Register_i  ({ra1, ra0}),
      .Read_Data_o      (rd_nb),
      .Clear_i          (clr),
      .Busy_o           (busy_nb),
      .Write_Drop_o     (drop_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                          input bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && !m_busy && we && a == wa) return wd;
      return mdl[a];
   endfunction

   function automatic logic [63:0] exp_pair(input bit byp);
      return {exp_rd(ra1, byp), exp_rd(ra0, byp)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      m_busy = 0;
      m_idx  = 0;
      m_drop = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      m_drop = m_busy && we;
      if (!m_busy) begin
         if (we && wa != 5'd0) mdl[wa] = wd;
         if (clr) begin
            m_busy = 1;
            m_idx  = 0;
         end
      end else begin
         mdl[m_idx] = 32'd0;
         m_idx++;
         if (m_idx == 32) m_busy = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      we  = 0;
      wa  = 0;
      wd  = 0;
      clr = 0;
   endtask

   task automatic test_reset();
      reset = 0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      ra0 = 5'd1;
      ra1 = 5'd2;
      #1;
      checks++;
      if (busy_b !== 1'b0 || busy_nb !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b/%b want=0", busy_b, busy_nb);
      end
      checks++;
      if (drop_b !== 1'b0 || drop_nb !== 1'b0) begin
         failures++;
         $display("FAIL reset_drop got=%b/%b want=0", drop_b, drop_nb);
      end
      checks++;
      if (rd_b !== 64'd0 || rd_nb !== 64'd0) begin
         failures++;
         $display("FAIL reset_read got=%h/%h want=0", rd_b, rd_nb);
      end
      reset = 1;
   endtask

   task automatic test_write_read();
      we = 1;
      wa = 5'd5;
      wd = 32'hDEADBEEF;
      tick();
      idle_inputs();
      ra0 = 5'd5;
      ra1 = 5'd5;
      #1;
      checks++;
      if (rd_b !== {2{32'hDEADBEEF}} || rd_nb !== exp_pair(0)) begin
         failures++;
         $display("FAIL write_read got=%h/%h want=%h",
                  rd_b, rd_nb, {2{32'hDEADBEEF}});
      end
   endtask

   task automatic test_bypass();
      we  = 1;
      wa  = 5'd7;
      wd  = 32'h12345678;
      ra0 = 5'd5;
      ra1 = 5'd7;
      #1;
      checks++;
      if (rd_b[63:32] !== 32'h12345678) begin
         failures++;
         $display("FAIL bypass_on got=%h want=12345678", rd_b[63:32]);
      end
      checks++;
      if (rd_nb[63:32] !== 32'd0) begin
         failures++;
         $display("FAIL bypass_off got=%h want=0", rd_nb[63:32]);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rd_nb[63:32] !== 32'h12345678) begin
         failures++;
         $display("FAIL bypass_commit got=%h want=12345678",
                  rd_nb[63:32]);
      end
   endtask

   task automatic test_zero_reg();
      we  = 1;
      wa  = 5'd0;
      wd  = 32'hFFFFFFFF;
      ra0 = 5'd0;
      ra1 = 5'd0;
      #1;
      checks++;
      if (rd_b !== 64'd0 || rd_nb !== 64'd0) begin
         failures++;
         $display("FAIL zero_bypass got=%h/%h want=0", rd_b, rd_nb);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rd_b !== 64'd0 || drop_b !== 1'b0 || drop_nb !== 1'b0) begin
         failures++;
         $display("FAIL zero_write got=%h drop=%b want=0 drop=0",
                  rd_b, drop_b);
      end
   endtask

   task automatic test_random(input int n, input int clr_pct);
      for (int i = 0; i < n; i++) begin
         we  = 1'($urandom);
         wa  = 5'($urandom);
         wd  = $urandom;
         ra0 = ($urandom_range(2, 0) == 0) ? wa : 5'($urandom);
         ra1 = ($urandom_range(2, 0) == 0) ? wa : 5'($urandom);
         clr = ($urandom_range(99, 0) < clr_pct);
         #1;
         checks++;
         if (rd_b !== exp_pair(1) || rd_nb !== exp_pair(0)) begin
            failures++;
            $display("FAIL rand_read[%0d] got=%h/%h want=%h/%h",
                     i, rd_b, rd_nb, exp_pair(1), exp_pair(0));
         end
         checks++;
         if (busy_b !== m_busy || drop_b !== m_drop ||
             busy_nb !== m_busy || drop_nb !== m_drop) begin
            failures++;
            $display("FAIL rand_ctrl[%0d] got=%b%b want=%b%b",
                     i, busy_b, drop_b, m_busy, m_drop);
         end
         tick();
      end
      idle_inputs();
      while (m_busy) tick();
   endtask

   task automatic test_clear();
      int n;
      int bad;
      for (int a = 1; a < 32; a++) begin
         we = 1;
         wa = 5'(a);
         wd = 32'hA5000000 | 32'(a);
         tick();
      end
      idle_inputs();
      clr = 1;
      tick();
      n = 0;
      while (busy_b && n < 40) begin
         we  = 0;
         clr = (m_idx < 30) ? 1'($urandom) : 1'b0;
         ra0 = 5'($urandom);
         ra1 = 5'($urandom);
         #1;
         checks++;
         if (rd_b !== exp_pair(1) || busy_nb !== m_busy) begin
            failures++;
            $display("FAIL clear_read[%0d] got=%h want=%h",
                     n, rd_b, exp_pair(1));
         end
         n++;
         tick();
      end
      clr = 0;
      checks++;
      if (n !== 32) begin
         failures++;
         $display("FAIL clear_len got=%0d want=32", n);
      end
      bad = 0;
      for (int a = 0; a < 32; a++) begin
         ra0 = 5'(a);
         ra1 = 5'(31 - a);
         #1;
         if (rd_b !== 64'd0 || rd_nb !== 64'd0) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL clear_all got=%0d nonzero want=0", bad);
      end
   endtask

   task automatic test_drop_in_clear();
      we = 1;
      wa = 5'd3;
      wd = 32'h33333333;
      tick();
      idle_inputs();
      clr = 1;
      tick();
      clr = 0;
      tick();
      tick();
      tick();
      we  = 1;
      wa  = 5'd3;
      wd  = 32'hCAFEF00D;
      ra0 = 5'd3;
      ra1 = 5'd3;
      #1;
      checks++;
      if (rd_b !== {2{32'h33333333}}) begin
         failures++;
         $display("FAIL clear_nobypass got=%h want=%h",
                  rd_b, {2{32'h33333333}});
      end
      tick();
      we = 0;
      #1;
      checks++;
      if (drop_b !== 1'b1 || drop_nb !== 1'b1 || rd_b !== 64'd0) begin
         failures++;
         $display("FAIL drop_pulse got=%b r3=%h want=1 r3=0",
                  drop_b, rd_b[31:0]);
      end
      tick();
      #1;
      checks++;
      if (drop_b !== 1'b0 || rd_b !== 64'd0) begin
         failures++;
         $display("FAIL drop_end got=%b r3=%h want=0 r3=0",
                  drop_b, rd_b[31:0]);
      end
      while (m_busy) tick();
   endtask

   task automatic test_reset_mid_clear();
      int bad;
      for (int a = 1; a < 32; a += 3) begin
         we = 1;
         wa = 5'(a);
         wd = $urandom | 32'h1;
         tick();
      end
      idle_inputs();
      clr = 1;
      tick();
      clr = 0;
      for (int i = 0; i < 9; i++) tick();
      reset = 0;
      model_reset();
      #1;
      checks++;
      if (busy_b !== 1'b0 || busy_nb !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_busy got=%b want=0", busy_b);
      end
      @(negedge clk);
      reset = 1;
      bad = 0;
      for (int a = 0; a < 32; a++) begin
         ra0 = 5'(a);
         ra1 = 5'(a ^ 5'h1f);
         #1;
         if (rd_b !== 64'd0 || rd_nb !== 64'd0 || busy_b) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL mid_reset_regs got=%0d bad want=0", bad);
      end
      we = 1;
      wa = 5'd9;
      wd = 32'h0BADF00D;
      tick();
      idle_inputs();
      ra0 = 5'd9;
      #1;
      checks++;
      if (rd_b[31:0] !== 32'h0BADF00D) begin
         failures++;
         $display("FAIL mid_reset_write got=%h want=0badf00d",
                  rd_b[31:0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] prev;
      prev = 5'd1;
      for (int i = 0; i < 20; i++) begin
         we  = 1;
         wa  = 5'($urandom_range(31, 1));
         wd  = $urandom;
         ra0 = prev;
         ra1 = wa;
         #1;
         checks++;
         if (rd_b !== exp_pair(1) || rd_nb !== exp_pair(0)) begin
            failures++;
            $display("FAIL b2b[%0d] got=%h/%h want=%h/%h",
                     i, rd_b, rd_nb, exp_pair(1), exp_pair(0));
         end
         prev = wa;
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      ra0      = 0;
      ra1      = 0;
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_random(300, 0);
      test_clear();
      test_drop_in_clear();
      test_reset_mid_clear();
      test_back_to_back();
      test_random(400, 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
